// File: rtl/vscale_seq_muldiv_pkg.sv
// vscale_seq_muldiv_pkg
//   Shared constants for the iterative RV32M multiply/divide unit:
//   datapath width, M-extension funct3 op codes, FSM state encodings and
//   small op-decode helpers used by the SETUP and FINISH stages.
package vscale_seq_muldiv_pkg;

  localparam int MD_XPR_LEN      = 32;
  localparam int MD_LOG2_XPR_LEN = 5;
  localparam int MD_OP_WIDTH     = 3;
  localparam int MD_STATE_WIDTH  = 3;

  typedef enum logic [MD_OP_WIDTH-1:0] {
    MD_OP_MUL    = 3'd0,
    MD_OP_MULH   = 3'd1,
    MD_OP_MULHSU = 3'd2,
    MD_OP_MULHU  = 3'd3,
    MD_OP_DIV    = 3'd4,
    MD_OP_DIVU   = 3'd5,
    MD_OP_REM    = 3'd6,
    MD_OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [MD_STATE_WIDTH-1:0] {
    MD_STATE_IDLE    = 3'd0,
    MD_STATE_SETUP   = 3'd1,
    MD_STATE_COMPUTE = 3'd2,
    MD_STATE_FINISH  = 3'd3,
    MD_STATE_DONE    = 3'd4
  } md_state_e;

  // Operand A is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic md_a_signed(input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_REM);
  endfunction

  // Operand B is treated as signed for MULH, DIV and REM (not MULHSU).
  function automatic logic md_b_signed(input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

  // Funct3 bit 2 separates the divide family from the multiply family.
  function automatic logic md_is_div(input logic [MD_OP_WIDTH-1:0] op);
    return op[2];
  endfunction

  // Remainder ops take the dividend's sign instead of the XOR of signs.
  function automatic logic md_is_rem(input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_OP_REM) || (op == MD_OP_REMU);
  endfunction

endpackage

// File: rtl/vscale_seq_muldiv.sv
// vscale_seq_muldiv
//   Iterative RV32M multiply/divide unit. Radix-2 shift-add multiply and
//   restoring shift-subtract divide, fixed 35-cycle request-to-response
//   latency (SETUP, XPR_LEN COMPUTE cycles, FINISH, registered result).
// Ports:
//   clk          clock, rising edge
//   reset_n      synchronous active-low reset
//   req_valid    request present          req_ready   unit idle, can accept
//   req_op       RV32M funct3             req_in_1/2  operands A / B
//   kill         flush the in-flight operation, no response
//   resp_valid   result available         resp_ready  consumer accepts
//   resp_result  result word
module vscale_seq_muldiv
  import vscale_seq_muldiv_pkg::*;
#(
  parameter int XPR_LEN      = MD_XPR_LEN,
  parameter int LOG2_XPR_LEN = MD_LOG2_XPR_LEN
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [XPR_LEN-1:0]     req_in_1,
  input  logic [XPR_LEN-1:0]     req_in_2,
  input  logic                   kill,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [XPR_LEN-1:0]     resp_result
);

  localparam logic [LOG2_XPR_LEN-1:0] CNT_LAST = LOG2_XPR_LEN'(XPR_LEN - 1);
  localparam logic [LOG2_XPR_LEN-1:0] CNT_ONE  = {{(LOG2_XPR_LEN-1){1'b0}}, 1'b1};
  localparam logic [LOG2_XPR_LEN-1:0] CNT_ZERO = {LOG2_XPR_LEN{1'b0}};
  localparam logic [XPR_LEN-1:0]      MIN_NEG  = {1'b1, {(XPR_LEN-1){1'b0}}};
  localparam logic [XPR_LEN-1:0]      ALL_ONES = {XPR_LEN{1'b1}};

  md_state_e               state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic [XPR_LEN-1:0]      a_q, a_d;          // raw operand A (needed for div-by-zero remainder)
  logic [XPR_LEN-1:0]      b_q, b_d;
  logic [XPR_LEN-1:0]      abs_a_q, abs_a_d;
  logic [XPR_LEN-1:0]      abs_b_q, abs_b_d;
  logic                    neg_q, neg_d;      // result must be negated in FINISH
  logic [LOG2_XPR_LEN-1:0] counter_q, counter_d;
  logic [2*XPR_LEN-1:0]    acc_q, acc_d;      // product, or quotient in the low half
  logic [XPR_LEN-1:0]      rem_q, rem_d;      // divider partial remainder
  logic [XPR_LEN-1:0]      result_q, result_d;
  logic                    req_ready_q, req_ready_d;
  logic                    resp_valid_q, resp_valid_d;

  // Combinational temporaries
  logic                    sa_s, sb_s;
  logic [XPR_LEN:0]        trial_s;           // shifted remainder, XPR_LEN+1 bits
  logic [XPR_LEN:0]        diff_s;            // trial minus divisor; MSB is the borrow
  logic [2*XPR_LEN-1:0]    prod_s;
  logic [XPR_LEN-1:0]      quot_s, remv_s;
  logic                    div_zero_s, div_ovf_s;

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;

  // Next-state, datapath and output-flag computation
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    abs_a_d    = abs_a_q;
    abs_b_d    = abs_b_q;
    neg_d      = neg_q;
    counter_d  = counter_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    result_d   = result_q;
    sa_s       = 1'b0;
    sb_s       = 1'b0;
    trial_s    = {(XPR_LEN+1){1'b0}};
    diff_s     = {(XPR_LEN+1){1'b0}};
    prod_s     = {(2*XPR_LEN){1'b0}};
    quot_s     = {XPR_LEN{1'b0}};
    remv_s     = {XPR_LEN{1'b0}};
    div_zero_s = 1'b0;
    div_ovf_s  = 1'b0;

    if ((state_q != MD_STATE_IDLE) && kill) begin
      // Flush: abandon the operation, no response, result register untouched
      state_d = MD_STATE_IDLE;
    end else begin
      case (state_q)
        MD_STATE_IDLE: begin
          if (req_valid && !kill) begin
            op_d    = req_op;
            a_d     = req_in_1;
            b_d     = req_in_2;
            state_d = MD_STATE_SETUP;
          end else begin
            state_d = MD_STATE_IDLE;
          end
        end

        MD_STATE_SETUP: begin
          sa_s      = md_a_signed(op_q) & a_q[XPR_LEN-1];
          sb_s      = md_b_signed(op_q) & b_q[XPR_LEN-1];
          abs_a_d   = sa_s ? (~a_q + {{(XPR_LEN-1){1'b0}}, 1'b1}) : a_q;
          abs_b_d   = sb_s ? (~b_q + {{(XPR_LEN-1){1'b0}}, 1'b1}) : b_q;
          neg_d     = md_is_rem(op_q) ? sa_s : (sa_s ^ sb_s);
          counter_d = CNT_LAST;
          acc_d     = {(2*XPR_LEN){1'b0}};
          rem_d     = {XPR_LEN{1'b0}};
          state_d   = MD_STATE_COMPUTE;
        end

        MD_STATE_COMPUTE: begin
          if (md_is_div(op_q)) begin
            // Bring in the next dividend bit (MSB first) and try the subtract
            trial_s = {rem_q, abs_a_q[counter_q]};
            diff_s  = trial_s - {1'b0, abs_b_q};
            if (!diff_s[XPR_LEN]) begin
              rem_d = diff_s[XPR_LEN-1:0];
              acc_d = {acc_q[2*XPR_LEN-2:0], 1'b1};
            end else begin
              rem_d = trial_s[XPR_LEN-1:0];
              acc_d = {acc_q[2*XPR_LEN-2:0], 1'b0};
            end
          end else begin
            // Horner-style: scan |B| from MSB, double the product and add |A|
            acc_d = {acc_q[2*XPR_LEN-2:0], 1'b0} +
                    (abs_b_q[counter_q] ? {{XPR_LEN{1'b0}}, abs_a_q}
                                        : {(2*XPR_LEN){1'b0}});
          end
          counter_d = counter_q - CNT_ONE;
          if (counter_q == CNT_ZERO) begin
            state_d = MD_STATE_FINISH;
          end else begin
            state_d = MD_STATE_COMPUTE;
          end
        end

        MD_STATE_FINISH: begin
          // Full-width negation first, then pick the word
          prod_s     = neg_q ? (~acc_q + {{(2*XPR_LEN-1){1'b0}}, 1'b1}) : acc_q;
          quot_s     = neg_q ? (~acc_q[XPR_LEN-1:0] + {{(XPR_LEN-1){1'b0}}, 1'b1})
                             : acc_q[XPR_LEN-1:0];
          remv_s     = neg_q ? (~rem_q + {{(XPR_LEN-1){1'b0}}, 1'b1}) : rem_q;
          div_zero_s = (b_q == {XPR_LEN{1'b0}});
          div_ovf_s  = md_b_signed(op_q) && (a_q == MIN_NEG) && (b_q == ALL_ONES);
          case (op_q)
            MD_OP_MUL:    result_d = prod_s[XPR_LEN-1:0];
            MD_OP_MULH,
            MD_OP_MULHSU,
            MD_OP_MULHU:  result_d = prod_s[2*XPR_LEN-1:XPR_LEN];
            MD_OP_DIV,
            MD_OP_DIVU: begin
              if (div_zero_s) begin
                result_d = ALL_ONES;
              end else if (div_ovf_s) begin
                result_d = MIN_NEG;
              end else begin
                result_d = quot_s;
              end
            end
            MD_OP_REM,
            MD_OP_REMU: begin
              if (div_zero_s) begin
                result_d = a_q;
              end else if (div_ovf_s) begin
                result_d = {XPR_LEN{1'b0}};
              end else begin
                result_d = remv_s;
              end
            end
            default:      result_d = {XPR_LEN{1'b0}};
          endcase
          state_d = MD_STATE_DONE;
        end

        MD_STATE_DONE: begin
          if (resp_ready) begin
            state_d = MD_STATE_IDLE;
          end else begin
            state_d = MD_STATE_DONE;
          end
        end

        default: state_d = MD_STATE_IDLE;
      endcase
    end

    req_ready_d  = (state_d == MD_STATE_IDLE);
    resp_valid_d = (state_d == MD_STATE_DONE);
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= MD_STATE_IDLE;
      op_q         <= 3'd0;
      a_q          <= {XPR_LEN{1'b0}};
      b_q          <= {XPR_LEN{1'b0}};
      abs_a_q      <= {XPR_LEN{1'b0}};
      abs_b_q      <= {XPR_LEN{1'b0}};
      neg_q        <= 1'b0;
      counter_q    <= CNT_ZERO;
      acc_q        <= {(2*XPR_LEN){1'b0}};
      rem_q        <= {XPR_LEN{1'b0}};
      result_q     <= {XPR_LEN{1'b0}};
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      abs_a_q      <= abs_a_d;
      abs_b_q      <= abs_b_d;
      neg_q        <= neg_d;
      counter_q    <= counter_d;
      acc_q        <= acc_d;
      rem_q        <= rem_d;
      result_q     <= result_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

endmodule

// File: tb/tb_vscale_seq_muldiv.sv
// tb_vscale_seq_muldiv
//   Self-checking bench: directed corner cases plus randomized ops compared
//   against an arithmetic reference model; also checks latency, response
//   hold, kill and mid-operation reset.
module tb_vscale_seq_muldiv;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_in_1;
  logic [31:0] req_in_2;
  logic        kill;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;

  int n_checks = 0;
  int n_errors = 0;

  vscale_seq_muldiv dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_in_1    (req_in_1),
    .req_in_2    (req_in_2),
    .kill        (kill),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Reference: RV32M semantics computed with 64-bit integer arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 64'sd0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Issue one request, check latency, hold the response for 'hold' cycles
  // (checking stability and that no new request is taken), then handshake.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int lat;
    logic [31:0] exp_v;
    exp_v = ref_md(op, a, b);
    @(negedge clk);
    check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_in_1 = a; req_in_2 = b; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 32'd35);
    check({tag, " result"}, resp_result, exp_v);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_op = 3'd0; req_in_1 = 32'd9; req_in_2 = 32'd9;
      check({tag, " busy req_ready"}, {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      check({tag, " hold valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, " hold result"}, resp_result, exp_v);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, " valid drop"}, {31'd0, resp_valid}, 32'd0);
    check({tag, " ready back"}, {31'd0, req_ready}, 32'd1);
    check({tag, " result kept"}, resp_result, exp_v);
  endtask

  // Accept a request and advance 'n' cycles past the accepting edge
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_in_1 = a; req_in_2 = b;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i < n; i++) @(negedge clk);
  endtask

  logic [31:0] ra, rb;
  logic [2:0]  rop;
  int          seen;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_in_1 = 32'd0; req_in_2 = 32'd0;
    kill = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset resp_result", resp_result, 32'd0);
    reset_n = 1'b1;

    // Directed cases
    run_op("mul_neg",   3'd0, 32'd7,          32'hFFFF_FFFD, 0);
    run_op("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'd2,         0);
    run_op("div_neg",   3'd4, 32'hFFFF_FFEC, 32'd3,         0);
    run_op("rem_neg",   3'd6, 32'hFFFF_FFEC, 32'd3,         0);
    run_op("divu",      3'd5, 32'd20,         32'd3,         0);
    run_op("divu_z",    3'd5, 32'd5,          32'd0,         0);
    run_op("remu_z",    3'd7, 32'd5,          32'd0,         0);
    run_op("div_z",     3'd4, 32'hFFFF_FFEC, 32'd0,         0);
    run_op("rem_z",     3'd6, 32'hFFFF_FFEC, 32'd0,         0);
    run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("hold5",     3'd0, 32'd123,        32'd456,       5);

    // Kill at COMPUTE cycle 10: no response, unit idle next cycle
    start_op(3'd0, 32'd1000, 32'd1000, 11);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill req_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    check("kill no resp", seen, 32'd0);
    run_op("after_kill", 3'd0, 32'd3, 32'd4, 0);

    // Kill in IDLE with a request present: not accepted
    @(negedge clk);
    req_valid = 1'b1; kill = 1'b1; req_op = 3'd0; req_in_1 = 32'd2; req_in_2 = 32'd2;
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0;
    check("idle kill ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    check("idle kill no resp", seen, 32'd0);

    // Kill in DONE wins over resp_ready
    start_op(3'd5, 32'd100, 32'd7, 35);
    check("done reached", {31'd0, resp_valid}, 32'd1);
    kill = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    kill = 1'b0; resp_ready = 1'b0;
    check("done kill valid", {31'd0, resp_valid}, 32'd0);
    check("done kill ready", {31'd0, req_ready}, 32'd1);

    // Reset mid-COMPUTE
    start_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 15);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst req_ready", {31'd0, req_ready}, 32'd1);
    check("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("midrst resp_result", resp_result, 32'd0);
    reset_n = 1'b1;

    // Randomized ops, with a bias towards corner operands
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       ra = 32'h8000_0000;
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vscale_seq_muldiv.md
Name: vscale_seq_muldiv

Overview:
Iterative multiply/divide unit for the RV32M extension. It is the consumer end of the execute-stage operand path: it takes the resolved operand A and operand B values (register, immediate, or constant) plus an M-extension op, and computes the result over multiple cycles with radix-2 shift-add or shift-subtract.
It uses valid/ready handshakes on the request side and the response side. The pipeline stalls on req_ready/resp_valid, and a kill input flushes an in-flight operation.

Parameters:
XPR_LEN, 32, datapath width in bits.
LOG2_XPR_LEN, 5, width of the iteration counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  synchronous reset, active-low.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request.
req_op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
req_in_1  input  XPR_LEN  operand A (rs1).
req_in_2  input  XPR_LEN  operand B (selected source B).
kill  input  1  abort the in-flight operation (pipeline flush).
resp_valid  output  1  result available.
resp_ready  input  1  consumer accepts the result.
resp_result  output  XPR_LEN  result value.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, counter=0, accumulators=0.
  - Outputs: req_ready=1, resp_valid=0, resp_result=0.
  - A reset mid-operation discards the operation with no response.
- States: IDLE -> SETUP -> COMPUTE -> FINISH -> DONE -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch op and operands and go to SETUP. No other state asserts req_ready.
- SETUP (1 cycle):
  - Decode the operand signedness:
    - MULH: both operands signed.
    - MULHSU: A signed, B unsigned.
    - DIV/REM: both operands signed.
    - Everything else: unsigned.
  - Take absolute values of the signed operands.
  - Record the result sign:
    - Products: sign of A XOR sign of B.
    - Quotient: the same XOR.
    - Remainder: sign of the dividend.
  - Load counter = XPR_LEN-1 and clear the 2*XPR_LEN-bit accumulator.
- COMPUTE (exactly XPR_LEN cycles):
  - Multiply: shift-add of |B| into the product, one bit per cycle.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - Counter decrements each cycle; go to FINISH when the counter reaches 0.
- FINISH (1 cycle):
  - Apply two's-complement negation if the result sign is set.
  - Select the output word:
    - MUL: low XPR_LEN bits.
    - MULH/MULHSU/MULHU: high XPR_LEN bits of the 2*XPR_LEN product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register the selection into resp_result.
- DONE:
  - resp_valid=1 and resp_result held stable until resp_ready=1.
  - On resp_valid&&resp_ready, go to IDLE. resp_valid drops the next cycle; resp_result keeps its last value.
- Latency: request accepted in cycle N gives resp_valid=1 in cycle N+35 (1 SETUP + 32 COMPUTE + 1 FINISH + 1 register). This is fixed for all ops and operands; there is no early-out.
- Divide special cases, produced in FINISH and overriding the datapath:
  - Divide by zero: quotient = all ones (0xFFFFFFFF) for both DIV and DIVU; remainder = dividend unmodified.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- Kill:
  - kill=1 in any non-IDLE state (including DONE): go to IDLE the next cycle; no response is delivered.
  - kill=1 in IDLE with req_valid=1: the request is not accepted.
  - kill has priority over resp_ready in the same cycle.
- Back-to-back: a new request can be accepted no earlier than the cycle after the response handshake.
- Width rules:
  - Accumulator is 2*XPR_LEN bits.
  - Divider partial remainder is XPR_LEN+1 bits so the subtract carry is visible.
  - Negation is computed at full width before the output word is selected.

Decomposition:
- Shared header vscale_md_constants.vh holds:
  - MD_OP_* codes (3-bit funct3 values) and MD_OP_WIDTH.
  - MD_STATE_* encodings and MD_STATE_WIDTH.
- vscale_ctrl_constants.vh and rv32_opcodes.vh keep supplying XPR_LEN.
- No sub-module is required. The FSM, counter and datapath stay in one module of about 250 lines.

Test Plan:
- MUL, A=7, B=0xFFFFFFFD (-3) -> resp_result=0xFFFFFFEB, resp_valid exactly 35 cycles after acceptance.
- MULH, A=B=0x80000000 -> 0x40000000. MULHU, A=B=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU, A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
- DIV, A=0xFFFFFFEC (-20), B=3 -> 0xFFFFFFFA (-6). REM, same operands -> 0xFFFFFFFE (-2). DIVU, A=20, B=3 -> 6.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, REMU 5%0 -> 5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- kill pulsed at COMPUTE cycle 10 -> no resp_valid; req_ready=1 next cycle; a following MUL 3*4 -> 12.
- resp_ready held low 5 cycles in DONE -> resp_valid and resp_result stable; a new req_valid is not accepted until after the handshake. reset_n=0 mid-COMPUTE -> all outputs at reset values the next cycle.
